// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: character FIFO feeding a UART-framed serial shifter.
// Each character goes out as: start bit (0), DWIDTH data bits LSB-first,
// an optional parity bit, then STOP_BITS stop bits (1). Whenever more
// characters are queued, frames follow each other with no idle gap.
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous, active-low reset
//   wr_en    push strobe, one character per cycle
//   wr_data  character to push
//   full     FIFO holds DEPTH characters
//   empty    FIFO holds no characters
//   count    current FIFO occupancy
//   busy     transmitter is not in IDLE
//   overflow sticky flag: a push was dropped because the FIFO was full
//   tx       registered serial line, idle high
module uart_tx_fifo #(
  parameter int DWIDTH       = 7,
  parameter int DEPTH        = 16,
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1,
  parameter int PARITY       = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [DWIDTH-1:0]          wr_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       busy,
  output logic                       overflow,
  output logic                       tx
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH+1);
  localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW   = $clog2(DWIDTH+1);

  localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(DEPTH);
  localparam logic [CW-1:0]   BAUD_LAST = CW'(CLKS_PER_BIT-1);
  localparam logic [BW-1:0]   DATA_LAST = BW'(DWIDTH-1);
  localparam logic [BW-1:0]   STOP_LAST = BW'(STOP_BITS-1);

  // Reject configurations the framing logic cannot represent.
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $fatal(1, "uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $fatal(1, "uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH-1)) != 0) begin : g_bad_depth
    $fatal(1, "uart_tx_fifo: DEPTH must be a power of two >= 2");
  end
  if (CLKS_PER_BIT < 1 || DWIDTH < 1) begin : g_bad_timing
    $fatal(1, "uart_tx_fifo: CLKS_PER_BIT and DWIDTH must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP
  } state_t;

  state_t              state;
  logic [DWIDTH-1:0]   mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       baud_cnt;
  logic [BW-1:0]       bit_cnt;
  logic [DWIDTH-1:0]   shift, shift_next, head;
  logic                par_bit, head_par;
  logic                push, pop, bit_end;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign busy    = (state != S_IDLE);
  assign push    = wr_en && !full;
  assign bit_end = (baud_cnt == BAUD_LAST);
  // A pop only ever happens on the last cycle of a frame or from IDLE, so
  // the next frame's start bit directly follows the previous stop bit.
  assign pop     = !empty && ((state == S_IDLE) ||
                   (state == S_STOP && bit_end && bit_cnt == STOP_LAST));

  assign head       = mem[rd_ptr];
  assign head_par   = (PARITY == 2) ? ~^head : ^head;
  assign shift_next = shift >> 1;

  // NOTE: the character store carries no reset; pointers and count define
  // which entries are valid, so clearing the array would only cost logic.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: every sequential block uses non-blocking assignments so all
  // registers update from the same pre-edge values, avoiding order races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A pop in the same cycle does not make room for a push into a full FIFO.
      if (wr_en && full) overflow <= 1'b1;
    end
  end

  // Framing FSM. tx is registered and always set to the level of the bit
  // the FSM is entering, so it changes exactly on bit boundaries.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
    end else begin
      if (state != S_IDLE) baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
      case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            state    <= S_START;
            tx       <= 1'b0;
            baud_cnt <= '0;
            shift    <= head;
            par_bit  <= head_par;
          end
        end
        S_START: begin
          if (bit_end) begin
            state   <= S_DATA;
            tx      <= shift[0];
            bit_cnt <= '0;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              if (PARITY != 0) begin
                state <= S_PAR;
                tx    <= par_bit;
              end else begin
                state <= S_STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shift   <= shift_next;
              tx      <= shift_next[0];
            end
          end
        end
        S_PAR: begin
          if (bit_end) begin
            state   <= S_STOP;
            tx      <= 1'b1;
            bit_cnt <= '0;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              if (pop) begin
                state   <= S_START;
                tx      <= 1'b0;
                shift   <= head;
                par_bit <= head_par;
              end else begin
                state <= S_IDLE;
                tx    <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Parametrised serial console transmitter. Replaces the single-string print buffer with a synthesizable character FIFO feeding a UART-framed serial shifter.
- The CPU pushes one character per cycle on a write strobe. The block serialises each character as: start bit 0, data LSB-first, optional parity, stop bit(s) 1.
- Sits between the CPU DISP/DISPC path and the board-level tx pin.

Parameters:
- DWIDTH, 7, character width in bits.
- DEPTH, 16, FIFO depth in characters; power of two, >=2.
- CLKS_PER_BIT, 4, clk cycles per serial bit; >=1.
- STOP_BITS, 1, number of stop bits; 1 or 2.
- PARITY, 0, parity mode: 0 none, 1 even, 2 odd.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- wr_en  input  1  push strobe, one character per cycle.
- wr_data  input  DWIDTH  character to push.
- full  output  1  FIFO holds DEPTH characters.
- empty  output  1  FIFO holds 0 characters.
- count  output  $clog2(DEPTH+1)  current FIFO occupancy.
- busy  output  1  high in any state other than IDLE.
- overflow  output  1  sticky: a push was dropped.
- tx  output  1  serial line, idle high; registered.

Behaviour:
- Clock/reset: one clock domain, clk. Reset is asynchronous and active-low (reset low clears the block immediately).
- Values while reset is asserted: tx=1, busy=0, full=0, empty=1, count=0, overflow=0, FIFO pointers 0, FSM in IDLE, baud counter 0.
- Reset mid-frame: the frame is aborted, tx returns to 1 immediately, and all queued characters are discarded.
- FIFO: circular buffer; read and write pointers wrap modulo DEPTH.
  - full = (count==DEPTH); empty = (count==0). Both are derived from the registered count.
  - Push happens when wr_en && !full. If wr_en && full, the character is dropped and overflow is set. This holds even if a pop occurs in the same cycle.
  - overflow clears only on reset.
  - Simultaneous accepted push and pop: count unchanged, both pointers advance.
- FSM states: IDLE, START, DATA, PAR, STOP. A baud counter runs 0..CLKS_PER_BIT-1 and each bit lasts exactly CLKS_PER_BIT cycles.
- IDLE: tx=1. If !empty, pop the head into the shift register and go to START the next cycle.
- START: tx=0 for one bit.
- DATA: tx=shift[0]; shift right at each bit end. After DWIDTH bits, go to PAR if PARITY!=0, else to STOP.
- PAR: tx = XOR of the character (even mode) or its inverse (odd mode), for one bit.
- STOP: tx=1 for STOP_BITS bits.
  - In the last cycle of STOP, if !empty, pop and go directly to START (back-to-back frames, no idle gap).
  - Otherwise go to IDLE.
- Latency: a push into an empty FIFO with the FSM in IDLE is accepted at edge N, popped in cycle N+1, and tx=0 is first driven in cycle N+2.
- Frame length: CLKS_PER_BIT*(1+DWIDTH+(PARITY?1:0)+STOP_BITS) cycles.
- tx is registered; no combinational path from wr_en to tx.
- Invalid parameter values (PARITY=3, STOP_BITS=0) are a fatal elaboration error.

Test Plan:
- Reset then idle (defaults): tx=1, empty=1, count=0, busy=0, overflow=0, held for 100 cycles.
- Single frame (DWIDTH=7, CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1): push 7'h41 -> tx low 4 cycles, then bits 1,0,0,0,0,0,1 at 4 cycles each, then high 4 cycles. Total 36 cycles; busy drops 36 cycles after START entry.
- Parity: push 7'h41 with PARITY=1 -> parity bit 0; with PARITY=2 -> parity bit 1. STOP_BITS=2 -> tx high 8 cycles before IDLE.
- Back-to-back: push 7'h48 and 7'h69 on consecutive cycles -> the second start bit immediately follows the first stop bit, busy never drops, and count returns to 0.
- Overflow (DEPTH=4): push 6 characters on 6 consecutive cycles from idle -> 5 accepted (one popped at cycle 1), the 6th dropped. overflow=1 and stays 1; full=1 after cycle 4; transmitted order matches push order.
- Reset mid-frame: assert reset low during DATA with 3 characters queued -> tx=1 and count=0 immediately, with no clk edge needed. After release with no pushes, no further frames are emitted.
